// File: rtl/riscv_32i_defs_pkg.sv
// rtl/riscv_32i_defs_pkg.sv - RV32I load/store width encodings and LSU decode helpers
package riscv_32i_defs_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_e;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
        else
            return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

    // Halfword codes are shared by LH/SH, word codes by LW/SW.
    function automatic logic misaligned_access(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            LH, LHU: return off[0];
            LW:      return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and data memory signals of the load/store unit
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        misaligned;
    logic        mem_wr_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    modport slave (
        input  req_valid, req_is_store, funct3, addr, store_data, mem_rd_data,
        output req_ready, resp_valid, load_data, misaligned, mem_wr_sel, mem_addr, mem_wr_data
    );

    modport master (
        output req_valid, req_is_store, funct3, addr, store_data, mem_rd_data,
        input  req_ready, resp_valid, load_data, misaligned, mem_wr_sel, mem_addr, mem_wr_data
    );

endinterface

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - load lane extract/extend and sub-word store merge (combinational)
module lsu_data_align
    import riscv_32i_defs_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    input  logic        i_is_store,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
    end

    assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_load_data = 32'h0;
        if (!i_is_store) begin
            case (i_funct3)
                LB:      o_load_data = {{24{w_byte[7]}}, w_byte};
                LH:      o_load_data = {{16{w_half[15]}}, w_half};
                LW:      o_load_data = i_word;
                LBU:     o_load_data = {24'h0, w_byte};
                LHU:     o_load_data = {16'h0, w_half};
                default: o_load_data = 32'h0;
            endcase
        end
    end

    // Only the addressed lane is replaced; the rest comes from the word just read.
    always_comb begin
        o_store_word = i_store_data;
        case (i_funct3)
            SB: begin
                case (i_offset)
                    2'd0:    o_store_word = {i_word[31:8], i_store_data[7:0]};
                    2'd1:    o_store_word = {i_word[31:16], i_store_data[7:0], i_word[7:0]};
                    2'd2:    o_store_word = {i_word[31:24], i_store_data[7:0], i_word[15:0]};
                    default: o_store_word = {i_store_data[7:0], i_word[23:0]};
                endcase
            end
            SH:      o_store_word = i_offset[1] ? {i_store_data[15:0], i_word[15:0]}
                                                : {i_word[31:16], i_store_data[15:0]};
            default: o_store_word = i_store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit FSM with read-modify-write sub-word stores
// Define LSU_MISALIGN_TRAP_EN to complete misaligned LH/LHU/SH/LW/SW as errors instead of aligning them.
module load_store_unit
    import riscv_32i_defs_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_e;

    state_e      r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [31:0] r_store_data;
    logic        r_is_store;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_load_data;
    logic        r_misaligned;
    logic        r_mem_wr_sel;
    logic [31:0] r_mem_wr_data;

    logic        w_legal;
    logic        w_trap;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;

    assign w_legal = funct3_legal(bus.req_is_store, bus.funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = w_legal && misaligned_access(bus.funct3, bus.addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    lsu_data_align u_align (
        .i_word       (bus.mem_rd_data),
        .i_offset     (r_addr[1:0]),
        .i_funct3     (r_funct3),
        .i_is_store   (r_is_store),
        .i_store_data (r_store_data),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_addr        <= 32'h0;
            r_funct3      <= 3'b000;
            r_store_data  <= 32'h0;
            r_is_store    <= 1'b0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_load_data   <= 32'h0;
            r_misaligned  <= 1'b0;
            r_mem_wr_sel  <= 1'b0;
            r_mem_wr_data <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_addr       <= bus.addr;
                        r_funct3     <= bus.funct3;
                        r_store_data <= bus.store_data;
                        r_is_store   <= bus.req_is_store;
                        r_req_ready  <= 1'b0;
                        if (!w_legal || w_trap) begin
                            r_state      <= DONE;
                            r_resp_valid <= 1'b1;
                            r_misaligned <= w_trap;
                        end else if (!bus.req_is_store) begin
                            r_state <= LOAD;
                        end else if (bus.funct3 == SW) begin
                            r_state       <= WRITE;
                            r_mem_wr_sel  <= 1'b1;
                            r_mem_wr_data <= bus.store_data;
                        end else begin
                            r_state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    r_load_data  <= w_load_data;
                    r_resp_valid <= 1'b1;
                    r_state      <= DONE;
                end
                RMW_RD: begin
                    r_mem_wr_data <= w_store_word;
                    r_mem_wr_sel  <= 1'b1;
                    r_state       <= WRITE;
                end
                WRITE: begin
                    r_mem_wr_sel  <= 1'b0;
                    r_mem_wr_data <= 32'h0;
                    r_resp_valid  <= 1'b1;
                    r_state       <= DONE;
                end
                DONE: begin
                    r_resp_valid <= 1'b0;
                    r_load_data  <= 32'h0;
                    r_misaligned <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.load_data   = r_load_data;
    assign bus.misaligned  = r_misaligned;
    assign bus.mem_wr_sel  = r_mem_wr_sel;
    assign bus.mem_wr_data = r_mem_wr_data;
    assign bus.mem_addr    = (r_state == IDLE) ? 32'h0 : {r_addr[31:2], 2'b00};

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: req_valid  in  1  core presents a memory request.
REQ-004 SHALL have: req_ready  out  1  unit idle, request accepted on clk edge when req_valid&&req_ready.
REQ-005 SHALL have: req_is_store  in  1  1=store, 0=load.
REQ-006 SHALL have: funct3  in  3  RV32I width code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-007 SHALL have: addr  in  32  byte address.
REQ-008 SHALL have: store_data  in  32  rs2 value, sub-word data in low bits.
REQ-009 SHALL have: resp_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL have: load_data  out  32  extended load result, valid while resp_valid.
REQ-011 SHALL have: misaligned  out  1  error flag, valid while resp_valid.
REQ-012 SHALL have: mem_wr_sel / mem_addr / mem_wr_data  out  1/32/32  to data_mem; mem_rd_data  in  32  combinational data_mem read.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RMW_RD, WRITE, DONE; req_ready=1 only in IDLE; requests while busy ignored.
REQ-014 SHALL latch addr, funct3, store_data, req_is_store on acceptance.
REQ-015 SHALL drive mem_addr = {addr_q[31:2],2'b00} in every non-IDLE state; mem_wr_sel=1 only in WRITE.
REQ-016 Load: IDLE->LOAD->DONE; load_data registered from mem_rd_data at LOAD exit; resp_valid 2 cycles after acceptance edge.
REQ-017 Load extraction: byte lane addr_q[1:0], half lane addr_q[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-018 SW: IDLE->WRITE->DONE, mem_wr_data=store_data_q.
REQ-019 SB/SH: IDLE->RMW_RD (capture mem_rd_data)->WRITE->DONE; mem_wr_data = captured word with addressed lane replaced by store_data_q[7:0]/[15:0], other lanes unchanged.
REQ-020 DONE: resp_valid=1 for exactly one cycle, then IDLE; load_data=0 for stores.
REQ-021 Illegal funct3 (load 011/110/111, store 011-111): IDLE->DONE, no write, load_data=0, misaligned=0.
REQ-022 Back-to-back: new request accepted in first IDLE cycle after DONE; RMW read SHALL observe data written by any prior completed store.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, req_ready=1, resp_valid=0, load_data=0, misaligned=0, mem_wr_sel=0, mem_addr=0, mem_wr_data=0, latched request cleared.
REQ-024 Reset mid-RMW SHALL abort with no memory write; memory contents untouched.

Configuration
REQ-025 Macro LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL go IDLE->DONE with misaligned=1, no write, load_data=0.
REQ-026 Macro undefined: misaligned tied 0; offending low address bits ignored (half uses addr[1], word uses aligned word).

Structure
REQ-027 Load/store funct3 encodings SHALL live as typedef enum in riscv_32i_defs_pkg; FSM state enum local to module.
REQ-028 Lane extract/sign-extend and store-merge logic SHALL be a combinational sub-module lsu_data_align.

Verification
REQ-029 SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> write in WRITE cycle, load_data=0xDEADBEEF at resp_valid, 2-cycle load latency.
REQ-030 After REQ-029, SB addr=0x11 data=0x55, LW 0x10 -> 0xDEAD55EF; LB 0x11 -> 0x00000055; LBU 0x13 -> 0x000000DE; LB 0x13 -> 0xFFFFFFDE.
REQ-031 SH addr=0x22 data=0x8001 over word 0 -> LW 0x20 = 0x80010000; LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001.
REQ-032 With LSU_MISALIGN_TRAP_EN: SW addr=0x31 -> misaligned=1, resp_valid one cycle after acceptance, LW 0x30 unchanged; without macro LW 0x31 returns word 0x30.
REQ-033 rst_n low during SB RMW_RD at 0x40 (prior 0x11223344) -> req_ready=1 immediately, no write, LW 0x40 = 0x11223344.
REQ-034 req_valid held high through busy cycles and funct3=3'b111 load -> only one acceptance per IDLE, illegal op completes with load_data=0, misaligned=0.
